// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM and ALU_control:
// state enum, opcodes, ALUop and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_EXECUTE,
    ST_ALU_WB,
    ST_BRANCH,
    ST_JUMP,
    ST_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADDU  = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_BNE   = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Instruction class dispatch out of DECODE; anything unrecognised traps.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:       return ST_EXECUTE;
      OP_LW, OP_SW:   return ST_MEM_ADDR;
      OP_BEQ, OP_BNE: return ST_BRANCH;
      OP_J:           return ST_JUMP;
      default:        return ST_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control bus between the main control FSM (master) and the multicycle
// datapath / memory (slave).
interface multicycle_main_control_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, retired
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS core: sequences each instruction,
// decodes datapath controls from state, counts retirements, traps illegal ops.
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_main_control_if.master ctrl
);

  state_t           state;
  logic             is_lw;
  logic             is_bne;
  logic [CNT_W-1:0] cnt;
  logic             retire;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;

  always_comb begin
    retire = (state == ST_MEM_WB) || (state == ST_ALU_WB) ||
             (state == ST_BRANCH) || (state == ST_JUMP) ||
             ((state == ST_MEM_WRITE) && ctrl.mem_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_FETCH;
      is_lw  <= 1'b0;
      is_bne <= 1'b0;
      cnt    <= '0;
    end else begin
      if (retire) cnt <= cnt + CNT_W'(1);
      case (state)
        ST_FETCH:     if (ctrl.mem_ready) state <= ST_DECODE;
        ST_DECODE: begin
          is_lw  <= (ctrl.opcode == OP_LW);
          is_bne <= (ctrl.opcode == OP_BNE);
          state  <= decode_next(ctrl.opcode);
        end
        ST_MEM_ADDR:  state <= is_lw ? ST_MEM_READ : ST_MEM_WRITE;
        ST_MEM_READ:  if (ctrl.mem_ready) state <= ST_MEM_WB;
        ST_MEM_WRITE: if (ctrl.mem_ready) state <= ST_FETCH;
        ST_EXECUTE:   state <= ST_ALU_WB;
        ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JUMP: state <= ST_FETCH;
        ST_TRAP:      state <= ST_TRAP;
        default:      state <= ST_FETCH;
      endcase
    end
  end

  // Moore decode, except the FETCH loads which complete with the memory.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADDU;
    pc_source     = PCSRC_ALU;
    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = ctrl.mem_ready;
        pc_write  = ctrl.mem_ready;
      end
      ST_DECODE:    alu_src_b = SRCB_IMM_SH2;
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTYPE;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        alu_op        = is_bne ? ALUOP_BNE : ALUOP_BEQ;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
    // Reset must silence the datapath immediately, without waiting for a clock.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
    end
  end

  assign ctrl.pc_write      = pc_write;
  assign ctrl.pc_write_cond = pc_write_cond;
  assign ctrl.iord          = iord;
  assign ctrl.mem_read      = mem_read;
  assign ctrl.mem_write     = mem_write;
  assign ctrl.ir_write      = ir_write;
  assign ctrl.mem_to_reg    = mem_to_reg;
  assign ctrl.reg_dst       = reg_dst;
  assign ctrl.reg_write     = reg_write;
  assign ctrl.alu_src_a     = alu_src_a;
  assign ctrl.alu_src_b     = alu_src_b;
  assign ctrl.alu_op        = alu_op;
  assign ctrl.pc_source     = pc_source;
  assign ctrl.illegal_op    = (state == ST_TRAP);
  assign ctrl.retired       = cnt;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: instruction-level reference model with
// randomized memory stalls, opcodes and don't-care mem_ready.
module tb_multicycle_main_control;

  localparam int CNT_W = 4;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
  localparam int P_EX = 6, P_AWB = 7, P_BR = 8, P_J = 9, P_TRAP = 10, P_RST = 11;

  localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
  localparam logic [5:0] BEQ_OP = 6'b000100, BNE_OP = 6'b000101, J_OP = 6'b000010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_main_control_if #(.CNT_W(CNT_W)) bus ();
  multicycle_main_control #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .ctrl(bus));

  int   errors = 0;
  int   checks = 0;
  int   model_retired = 0;
  logic cur_bne = 1'b0;

  // {pcw, pcwc, iord, mem_rd, mem_wr, ir_wr, m2r, reg_dst, reg_wr, src_a, src_b, alu_op, pc_src, illegal}
  function automatic logic [16:0] expv(input int ph, input logic r, input logic bne);
    case (ph)
      P_F:    return {r,    1'b0, 1'b0, 1'b1, 1'b0, r,    1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
      P_D:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0};
      P_MA:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
      P_MR:   return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
      P_MWB:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
      P_MW:   return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
      P_EX:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 2'b00, 1'b0};
      P_AWB:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
      P_BR:   return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,
                      (bne ? 2'b10 : 2'b01), 2'b01, 1'b0};
      P_J:    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0};
      P_TRAP: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
      default: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
    endcase
  endfunction

  function automatic logic [16:0] observed();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == R_OP) || (op == LW_OP) || (op == SW_OP) ||
           (op == BEQ_OP) || (op == BNE_OP) || (op == J_OP);
  endfunction

  // One cycle of the model: drive mem_ready mid-cycle, then compare the phase's outputs and count.
  task automatic step(input int ph, input logic r, input string nm);
    logic [16:0]      obs, exp;
    logic [CNT_W-1:0] exp_ret;
    @(negedge clk);
    bus.mem_ready = r;
    #1;
    obs = observed();
    exp = expv(ph, r, cur_bne);
    exp_ret = CNT_W'(model_retired);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: ctrl outputs got %b required %b", nm, obs, exp);
    end
    checks++;
    if (bus.retired !== exp_ret) begin
      errors++;
      $display("FAIL %s_retired: got %0d required %0d", nm, bus.retired, exp_ret);
    end
  endtask

  task automatic retire_one();
    model_retired = (model_retired + 1) % (1 << CNT_W);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
    bus.opcode = op;
    cur_bne = (op == BNE_OP);
    repeat (fstall) step(P_F, 1'b0, "fetch_stall");
    step(P_F, 1'b1, "fetch");
    step(P_D, rnd_bit(), "decode");
    case (op)
      R_OP: begin
        step(P_EX, rnd_bit(), "execute");
        step(P_AWB, rnd_bit(), "alu_wb");
        retire_one();
      end
      LW_OP: begin
        step(P_MA, rnd_bit(), "lw_addr");
        repeat (mstall) step(P_MR, 1'b0, "mem_read_stall");
        step(P_MR, 1'b1, "mem_read");
        step(P_MWB, rnd_bit(), "mem_wb");
        retire_one();
      end
      SW_OP: begin
        step(P_MA, rnd_bit(), "sw_addr");
        repeat (mstall) step(P_MW, 1'b0, "mem_write_stall");
        step(P_MW, 1'b1, "mem_write");
        retire_one();
      end
      BEQ_OP, BNE_OP: begin
        step(P_BR, rnd_bit(), cur_bne ? "bne" : "beq");
        retire_one();
      end
      J_OP: begin
        step(P_J, rnd_bit(), "jump");
        retire_one();
      end
      default: repeat (10) step(P_TRAP, rnd_bit(), "trap_hold");
    endcase
  endtask

  // Pulse reset between clock edges; leave mem_ready low so FETCH holds afterwards.
  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (observed() !== expv(P_RST, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL %s: ctrl outputs got %b required %b", nm, observed(), expv(P_RST, 1'b0, 1'b0));
    end
    checks++;
    if (bus.retired !== '0) begin
      errors++;
      $display("FAIL %s_retired: got %0d required 0", nm, bus.retired);
    end
    bus.mem_ready = 1'b0;
    #1 rst = 1'b0;
    model_retired = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = R_OP;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (observed() !== expv(P_RST, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_outputs: got %b required %b", observed(), expv(P_RST, 1'b0, 1'b0));
    end
    checks++;
    if (bus.retired !== '0) begin
      errors++;
      $display("FAIL reset_retired: got %0d required 0", bus.retired);
    end
    bus.mem_ready = 1'b0;
    #1 rst = 1'b0;
    model_retired = 0;
  endtask

  task automatic test_rtype();
    run_instr(R_OP, 0, 0);
  endtask

  task automatic test_lw_stall();
    run_instr(LW_OP, 0, 2);
    run_instr(SW_OP, 1, 0);
  endtask

  task automatic test_branch();
    run_instr(BNE_OP, 0, 0);
    run_instr(BEQ_OP, 0, 0);
    run_instr(J_OP, 2, 0);
  endtask

  task automatic test_trap();
    logic [5:0] op;
    run_instr(6'b111111, 0, 0);
    do_reset("trap_reset");
    run_instr(R_OP, 0, 0);
    op = 6'($urandom);
    for (int k = 0; k < 64 && is_legal(op); k++) op = op + 6'd1;
    run_instr(op, 1, 0);
    do_reset("trap_reset2");
  endtask

  task automatic test_async_reset_write();
    run_instr(R_OP, 0, 0);
    bus.opcode = SW_OP;
    cur_bne = 1'b0;
    step(P_F, 1'b1, "sw_fetch");
    step(P_D, rnd_bit(), "sw_decode");
    step(P_MA, rnd_bit(), "sw_addr");
    step(P_MW, 1'b0, "sw_stall1");
    step(P_MW, 1'b0, "sw_stall2");
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_mem_write: got %b required 0", bus.mem_write);
    end
    checks++;
    if (bus.retired !== '0) begin
      errors++;
      $display("FAIL async_rst_retired: got %0d required 0", bus.retired);
    end
    checks++;
    if (observed() !== expv(P_RST, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL async_rst_outputs: got %b required %b", observed(), expv(P_RST, 1'b0, 1'b0));
    end
    #1 rst = 1'b0;
    model_retired = 0;
    run_instr(LW_OP, 0, 1);
  endtask

  task automatic test_wrap();
    do_reset("wrap_reset");
    repeat (17) run_instr(J_OP, 0, 0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.retired !== 4'd1) begin
      errors++;
      $display("FAIL counter_wrap: got %0d required 1", bus.retired);
    end
  endtask

  task automatic test_random();
    logic [5:0] op;
    int k;
    repeat (60) begin
      k = int'($urandom_range(0, 6));
      case (k)
        0: op = R_OP;
        1: op = LW_OP;
        2: op = SW_OP;
        3: op = BEQ_OP;
        4: op = BNE_OP;
        5: op = J_OP;
        default: begin
          op = 6'($urandom);
          for (int n = 0; n < 64 && is_legal(op); n++) op = op + 6'd1;
        end
      endcase
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if (!is_legal(op)) do_reset("random_trap_reset");
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'd0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_trap();
    test_async_reset_write();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
